register_dump: RTL and testbench

Debug read-out engine for the CPU register file. On a start pulse it walks a contiguous, optionally wrapping range of register indices through one combinational read port. It streams each register value, tagged with its index, out over a valid/ready interface at up to one word per cycle. It sits beside the register file, shares a read address port with the debug mux, and feeds the debug transport (UART/JTAG bridge).

---
 rtl/register_dump_if.sv | 23 ++
 rtl/register_dump.sv | 85 ++++++++
 tb/tb_register_dump.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/register_dump_if.sv
// register_dump_if: start/range request, register-file read port and output stream of the dump engine
interface register_dump_if;
  logic        start;
  logic [4:0]  first;
  logic [4:0]  last;
  logic [4:0]  ra;
  logic [31:0] rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_idx;
  logic        out_last;
  logic        busy;
  logic        done;
  modport master (
    input  start, first, last, rd, out_ready,
    output ra, out_valid, out_data, out_idx, out_last, busy, done
  );
  modport slave (
    output start, first, last, rd, out_ready,
    input  ra, out_valid, out_data, out_idx, out_last, busy, done
  );
endinterface

// File: rtl/register_dump.sv
// register_dump: walks a wrapping register index range and streams indexed values over valid/ready
module register_dump (
  input logic clk,
  input logic clr,
  register_dump_if.master bus
);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [5:0]  rem_q, rem_d;
  logic [31:0] out_data_q, out_data_d;
  logic [4:0]  out_idx_q, out_idx_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        hs, cap;
  assign hs  = out_valid_q && bus.out_ready;
  assign cap = state_q == SCAN && (!out_valid_q || bus.out_ready);
  // next state: latch range on start, capture into the single output stage, finish on the last handshake
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    if (state_q == IDLE && bus.start) begin
      idx_d   = bus.first;
      rem_d   = {1'b0, bus.last - bus.first} + 6'd1;
      busy_d  = 1'b1;
      state_d = SCAN;
    end
    if (cap) begin
      out_data_d  = bus.rd;
      out_idx_d   = idx_q;
      out_last_d  = rem_q == 6'd1;
      out_valid_d = 1'b1;
      idx_d       = idx_q + 5'd1;
      rem_d       = rem_q - 6'd1;
      state_d     = rem_q == 6'd1 ? DRAIN : SCAN;
    end else if (hs) begin
      out_valid_d = 1'b0;
    end
    if (state_q == DRAIN && hs) begin
      busy_d  = 1'b0;
      done_d  = 1'b1;
      state_d = IDLE;
    end
  end
  // state registers; clr discards any in-flight word and remaining range
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rem_q       <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end
  assign bus.ra        = state_q == SCAN ? idx_q : 5'd0;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_register_dump.sv
// tb_register_dump: scoreboard bench for register_dump with a bench-owned register file
module tb_register_dump;
  logic clk = 1'b0;
  logic clr;
  logic we3;
  logic [4:0] wa3;
  logic [31:0] wd3;
  logic [31:0] rf [32];
  logic [31:0] mrf [32];
  int n_tests = 0;
  int n_fail = 0;
  int n_words = 0;
  int cyc;
  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } exp_t;
  exp_t sb [$];
  register_dump_if bus();
  register_dump dut (.clk(clk), .clr(clr), .bus(bus.master));
  always #5 clk = ~clk;
  // register file: r0 never written, combinational read
  always @(posedge clk) if (we3 && wa3 != 5'd0) rf[wa3] <= wd3;
  assign bus.rd = bus.ra == 5'd0 ? 32'd0 : rf[bus.ra];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // consumer side: pop expectation on every handshake, verify hold while stalled
  logic stall = 1'b0;
  logic [31:0] h_data;
  logic [4:0] h_idx, h_ra;
  always @(negedge clk) begin
    if (clr) stall = 1'b0;
    else begin
      if (stall) begin
        chk("hold_valid", 64'(bus.out_valid), 64'd1);
        chk("hold_data", 64'(bus.out_data), 64'(h_data));
        chk("hold_idx", 64'(bus.out_idx), 64'(h_idx));
        chk("hold_ra", 64'(bus.ra), 64'(h_ra));
      end
      stall  = bus.out_valid && !bus.out_ready;
      h_data = bus.out_data;
      h_idx  = bus.out_idx;
      h_ra   = bus.ra;
      if (bus.out_valid && bus.out_ready) begin
        exp_t e;
        n_words++;
        if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
        else begin
          e = sb.pop_front();
          chk("word_idx", 64'(bus.out_idx), 64'(e.idx));
          chk("word_data", 64'(bus.out_data), 64'(e.data));
          chk("word_last", 64'(bus.out_last), 64'(e.last));
        end
      end
    end
  end
  task automatic start_dump(input logic [4:0] f, input logic [4:0] l, input bit poke20);
    int n;
    n = ((int'(l) - int'(f)) & 31) + 1;
    for (int k = 0; k < n; k++) begin
      exp_t e;
      logic [4:0] i;
      i = 5'((int'(f) + k) & 31);
      e.idx  = i;
      e.data = i == 5'd0 ? 32'd0 : (poke20 && i == 5'd20) ? 32'hDEAD_BEEF : mrf[i];
      e.last = k == n - 1;
      sb.push_back(e);
    end
    n_words = 0;
    bus.start = 1'b1;
    bus.first = f;
    bus.last  = l;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("start_busy", 64'(bus.busy), 64'd1);
    chk("start_ra", 64'(bus.ra), 64'(f));
  endtask
  task automatic wait_done(input int max, output int c);
    c = 0;
    while (!bus.done && c < max) begin
      @(posedge clk); #1;
      c++;
    end
    if (!bus.done) chk("done_timeout", 64'd0, 64'd1);
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask
  initial begin
    clr = 1'b1;
    we3 = 1'b0; wa3 = '0; wd3 = '0;
    bus.start = 1'b0; bus.first = '0; bus.last = '0; bus.out_ready = 1'b1;
    mrf[0] = 32'd0;
    for (int i = 1; i < 32; i++) begin
      we3 = 1'b1; wa3 = 5'(i); wd3 = 32'h1000_0000 + 32'(i);
      mrf[i] = wd3;
      @(posedge clk); #1;
    end
    we3 = 1'b0;
    chk("rst_ra", 64'(bus.ra), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data", 64'(bus.out_data), 64'd0);
    chk("rst_idx", 64'(bus.out_idx), 64'd0);
    chk("rst_last", 64'(bus.out_last), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    clr = 1'b0;
    @(posedge clk); #1;
    // full range, ready held high
    start_dump(5'd0, 5'd31, 1'b0);
    wait_done(40, cyc);
    chk("full_latency", 64'(cyc), 64'd33);
    chk("full_words", 64'(n_words), 64'd32);
    chk_idle("full");
    // wrapping range started in the DONE cycle
    start_dump(5'd30, 5'd1, 1'b0);
    wait_done(10, cyc);
    chk("wrap_latency", 64'(cyc), 64'd5);
    chk("wrap_words", 64'(n_words), 64'd4);
    chk_idle("wrap");
    // single word with three stalled cycles
    bus.out_ready = 1'b0;
    start_dump(5'd5, 5'd5, 1'b0);
    @(posedge clk); #1;
    chk("bp_valid", 64'(bus.out_valid), 64'd1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_no_done", 64'(bus.done), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_done", 64'(bus.done), 64'd1);
    chk("bp_words", 64'(n_words), 64'd1);
    chk_idle("bp");
    @(posedge clk); #1;
    chk("bp_done_pulse", 64'(bus.done), 64'd0);
    // random ready with a write to r20 before it is captured
    start_dump(5'd0, 5'd31, 1'b1);
    cyc = 0;
    while (!bus.done && cyc < 500) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      we3 = cyc == 2;
      wa3 = 5'd20;
      wd3 = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      cyc++;
    end
    we3 = 1'b0;
    bus.out_ready = 1'b1;
    mrf[20] = 32'hDEAD_BEEF;
    if (!bus.done) chk("rand_timeout", 64'd0, 64'd1);
    chk("rand_words", 64'(n_words), 64'd32);
    chk_idle("rand");
    // START during a dump is ignored
    start_dump(5'd2, 5'd6, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.first = 5'd10; bus.last = 5'd20;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(20, cyc);
    chk("ign_words", 64'(n_words), 64'd5);
    chk_idle("ign");
    // clear mid-dump, then a clean dump
    start_dump(5'd0, 5'd31, 1'b0);
    cyc = 0;
    while (n_words < 10 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    sb.delete();
    chk("clr_ra", 64'(bus.ra), 64'd0);
    chk("clr_valid", 64'(bus.out_valid), 64'd0);
    chk("clr_data", 64'(bus.out_data), 64'd0);
    chk("clr_idx", 64'(bus.out_idx), 64'd0);
    chk("clr_last", 64'(bus.out_last), 64'd0);
    chk("clr_busy", 64'(bus.busy), 64'd0);
    chk("clr_done", 64'(bus.done), 64'd0);
    @(posedge clk); #1;
    chk("clr_stays_idle", 64'(bus.busy), 64'd0);
    start_dump(5'd7, 5'd9, 1'b0);
    wait_done(10, cyc);
    chk("post_clr_latency", 64'(cyc), 64'd4);
    chk("post_clr_words", 64'(n_words), 64'd3);
    chk_idle("post_clr");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
